// File: rtl/mainfsm_lm.sv
// -----------------------------------------------------------------------------
// mainfsm_lm
//   Multicycle main control FSM for the ARM datapath, with long multiply
//   (UMULL/SMULL) support. It sequences fetch/decode/execute/writeback and
//   drives the raw strobes NextPC, RegW, MemW and Branch. Condition gating of
//   those strobes happens downstream in condlogic.
//   A second writeback state, MULHI, writes RdHi after RdLo. It is entered only
//   when the condition-gated IsLongMul is high while the FSM is in ALUWB.
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-high; forces State to FETCH
//   Op         in   instr[27:26]
//   Funct      in   instr[25:20]; Funct[5]=I bit, Funct[0]=L/S bit
//   IsLongMul  in   long multiply executing and condition passed
//   IRWrite    out  instruction register load enable
//   AdrSrc     out  memory address select: 0=PC, 1=ALUResult reg
//   ALUSrcA    out  ALU A select: 00=Rn, 01=PC
//   ALUSrcB    out  ALU B select: 00=Rm, 01=ExtImm, 10=const 4
//   ResultSrc  out  result select: 00=ALUOut, 01=Data, 10=ALUResult
//   ALUOp      out  1 = ALU decoder uses Funct, 0 = ADD
//   NextPC     out  PC update strobe
//   RegW       out  register write request (before condition gating)
//   MemW       out  memory write request (before condition gating)
//   Branch     out  branch request (before condition gating)
//   LongMulHi  out  selects RdHi destination and high product word
//   State      out  current state encoding
//
// Moore machine: every output decodes from the state register alone. The
// state register is the only storage in this block.
// -----------------------------------------------------------------------------
module mainfsm_lm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               IsLongMul,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               ALUOp,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               LongMulHi,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMRD    = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWR    = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9),
    MULHI    = STATE_W'(10),
    UNKNOWN  = STATE_W'(11)
  } state_t;

  // Kept as a plain vector so that unused encodings (12 and above) are
  // representable and can be recovered from.
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  // Funct[4:1] carry the ALU function, which the ALU decoder consumes; this
  // block only looks at the I and L/S bits.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register with asynchronous reset to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_d = BRANCH;
          2'b11:   state_d = UNKNOWN;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        state_d = MEMWB;
      end
      EXECUTER: begin
        state_d = ALUWB;
      end
      EXECUTEI: begin
        state_d = ALUWB;
      end
      ALUWB: begin
        // IsLongMul is already condition-gated, so a squashed long multiply
        // returns to FETCH without writing RdHi.
        state_d = IsLongMul ? MULHI : FETCH;
      end
      MEMWB, MEMWR, BRANCH, MULHI, UNKNOWN: begin
        state_d = FETCH;
      end
      default: begin
        // Illegal encodings self-recover.
        state_d = FETCH;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b01;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    LongMulHi = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        NextPC    = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b01;
        ALUOp     = 1'b0;
      end
      MEMRD: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
        MemW      = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b01;
        ALUOp     = 1'b1;
      end
      ALUWB: begin
        ResultSrc = 2'b00;
        RegW      = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b01;
        ALUOp     = 1'b0;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      MULHI: begin
        ResultSrc = 2'b00;
        RegW      = 1'b1;
        LongMulHi = 1'b1;
      end
      UNKNOWN: begin
        // Everything off, including the usual PC default on ALUSrcA.
        ALUSrcA   = 2'b00;
      end
      default: begin
        ALUSrcA   = 2'b00;
      end
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_mainfsm_lm.sv
// -----------------------------------------------------------------------------
// tb_mainfsm_lm
//   Scoreboard bench for mainfsm_lm. Each instruction pushes its expected
//   state trace (with the output vector expected in every state) into a queue;
//   the entries are popped and compared as the DUT steps through the states.
// -----------------------------------------------------------------------------
module tb_mainfsm_lm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IsLongMul;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       LongMulHi;
  logic [3:0] State;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] state;
    logic [13:0] outs;
  } exp_t;

  exp_t sb_q[$];

  logic [13:0] dut_outs;
  assign dut_outs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                     ALUOp, NextPC, RegW, MemW, Branch, LongMulHi};

  mainfsm_lm #(.STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IsLongMul (IsLongMul),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .LongMulHi (LongMulHi),
    .State     (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector for each state, straight from the state table:
  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, LongMulHi}
  function automatic logic [13:0] exp_outs(input logic [3:0] s);
    case (s)
      4'd0:    return {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd1:    return {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd2:    return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd3:    return {1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd4:    return {1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      4'd5:    return {1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      4'd6:    return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd7:    return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      4'd8:    return {1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      4'd9:    return {1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      4'd10:   return {1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      default: return 14'd0;
    endcase
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one instruction starting in FETCH (called at a falling edge).
  // st/lm give, per cycle, the expected state and the IsLongMul value driven.
  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                           input int len, input logic [3:0] st [6], input logic lm [6]);
    exp_t e;
    Op    = op;
    Funct = funct;
    for (int i = 0; i < len; i++) begin
      e.tag   = $sformatf("%s_c%0d", name, i);
      e.state = st[i];
      e.outs  = exp_outs(st[i]);
      sb_q.push_back(e);
    end
    for (int i = 0; i < len; i++) begin
      IsLongMul = lm[i];
      #1;
      if (sb_q.size() == 0) begin
        check({name, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_state"}, {28'd0, State}, {28'd0, e.state});
        check({e.tag, "_outs"}, {18'd0, dut_outs}, {18'd0, e.outs});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b1;
    Op        = 2'b00;
    Funct     = 6'd0;
    IsLongMul = 1'b0;

    // Reset held: FETCH, and FETCH outputs, across clock edges.
    repeat (2) @(negedge clk);
    check("reset_state", {28'd0, State}, 32'd0);
    check("reset_outs", {18'd0, dut_outs}, {18'd0, exp_outs(4'd0)});
    reset = 1'b0;

    // LDR, IsLongMul held high to show it is ignored outside ALUWB.
    run_instr("ldr", 2'b01, 6'b000001, 5, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0},
              '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    // STR.
    run_instr("str", 2'b01, 6'b000000, 4, '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0},
              '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    // ADD immediate; IsLongMul high before ALUWB but low in ALUWB.
    run_instr("addi", 2'b00, 6'b101000, 4, '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 4'd0},
              '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    // Long multiply, condition passed.
    run_instr("umull", 2'b00, 6'b001000, 5, '{4'd0, 4'd1, 4'd6, 4'd8, 4'd10, 4'd0},
              '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    // Long multiply squashed (IsLongMul low in ALUWB).
    run_instr("umull_sq", 2'b00, 6'b001000, 4, '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd0},
              '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    // Branch.
    run_instr("b", 2'b10, 6'b000000, 3, '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0},
              '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    // Undefined Op.
    run_instr("undef", 2'b11, 6'b111111, 3, '{4'd0, 4'd1, 4'd11, 4'd0, 4'd0, 4'd0},
              '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    #1;
    check("after_seq_state", {28'd0, State}, 32'd0);
    check("sb_drained", sb_q.size(), 32'd0);

    // Asynchronous reset in MEMRD, between clock edges.
    Op        = 2'b01;
    Funct     = 6'b000001;
    IsLongMul = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_memrd", {28'd0, State}, 32'd3);
    #2 reset = 1'b1;
    #1;
    check("async_reset_state", {28'd0, State}, 32'd0);
    check("async_reset_outs", {18'd0, dut_outs}, {18'd0, exp_outs(4'd0)});
    @(posedge clk);
    #1;
    check("reset_hold_state", {28'd0, State}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_release_state", {28'd0, State}, 32'd0);
    @(posedge clk);
    #1;
    check("post_reset_decode", {28'd0, State}, 32'd1);

    // Illegal encoding recovers to FETCH on the next edge.
    @(negedge clk);
    force dut.state_q = 4'd13;
    #1;
    check("illegal_state", {28'd0, State}, 32'd13);
    check("illegal_outs", {18'd0, dut_outs}, 32'd0);
    release dut.state_q;
    #1;
    check("illegal_held", {28'd0, State}, 32'd13);
    @(posedge clk);
    #1;
    check("illegal_recover", {28'd0, State}, 32'd0);
    check("illegal_recover_outs", {18'd0, dut_outs}, {18'd0, exp_outs(4'd0)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
